// File: rtl/fp32_div.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit per cycle.
// Build option: define FP32_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp32_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int unsigned ITERS = 26;
  localparam int unsigned EW    = 12;
  localparam int unsigned MW    = 24;
  localparam int unsigned RW    = MW + 1;
  localparam int unsigned CW    = 5;
  localparam logic [31:0] QNAN  = 32'h7FC00001;

  typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]        cnt;
  logic [MW-1:0]        divisor;
  logic [RW-1:0]        rem;
  logic [ITERS-1:0]     quo;
  logic signed [EW-1:0] exp_q;
  logic                 sign_q;
  logic [31:0]          res_q;
  logic                 busy_nx, done_nx;

  // Effective exponent and 24-bit significand with the leading one moved to bit 23.
  function automatic logic [EW+MW-1:0] unpack(input logic [30:0] x);
    logic [4:0] sh;
    sh = 5'd0;
    if (x[30:23] != 8'd0) return {EW'(x[30:23]), 1'b1, x[22:0]};
    for (int i = 0; i < 23; i++) if (x[i]) sh = 5'(23 - i);
    return {EW'(EW'(1) - EW'(sh)), MW'({1'b0, x[22:0]} << sh)};
  endfunction

  // Operand classification and special-case results.
  logic [EW+MW-1:0] ua_c, ub_c;
  logic             a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
  logic             sign_c, spec_c, accept_c;
  logic [31:0]      spec_res_c;

  always_comb begin
    ua_c     = unpack(a[30:0]);
    ub_c     = unpack(b[30:0]);
    a_nan_c  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_c  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf_c  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_c  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero_c = (a[30:0] == 31'd0);
    b_zero_c = (b[30:0] == 31'd0);
    sign_c   = a[31] ^ b[31];
    spec_c   = a_nan_c | b_nan_c | a_inf_c | b_inf_c | a_zero_c | b_zero_c;
    accept_c = (state == IDLE) && start && !busy;
    if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c))
      spec_res_c = QNAN;
    else if (a_inf_c || b_zero_c)
      spec_res_c = {sign_c, 8'hFF, 23'd0};
    else
      spec_res_c = {sign_c, 31'd0};
  end

  // One restoring-division step.
  logic             ge_c;
  logic [RW-1:0]    rem_nx_c;

  always_comb begin
    ge_c     = rem >= {1'b0, divisor};
    rem_nx_c = (ge_c ? rem - {1'b0, divisor} : rem) << 1;
  end

  // Normalise, denormalise, optionally round, and saturate the quotient.
  logic [22:0]          mant_c, frac_c;
  logic signed [EW-1:0] exp_c;
  logic [5:0]           sh_c;
  logic [7:0]           efield_c;
  logic [30:0]          body_c;
  logic [31:0]          pack_c;
`ifdef FP32_DIV_ROUND_EN
  logic                 guard_c, sticky_c, rnd_c;
  logic [48:0]          full_c;
`endif

  always_comb begin
    if (quo[ITERS-1]) begin
      mant_c = quo[24:2];
      exp_c  = exp_q;
    end else begin
      mant_c = quo[23:1];
      exp_c  = exp_q - EW'(1);
    end
    if (exp_c > 12'sd0)        sh_c = 6'd0;
    else if (exp_c < -12'sd24) sh_c = 6'd25;
    else                       sh_c = 6'(12'sd1 - exp_c);
    frac_c   = 23'({1'b1, mant_c} >> sh_c);
    efield_c = (exp_c > 12'sd0) ? exp_c[7:0] : 8'd0;
    body_c   = {efield_c, frac_c};
`ifdef FP32_DIV_ROUND_EN
    guard_c  = quo[ITERS-1] ? quo[1] : quo[0];
    sticky_c = (quo[ITERS-1] & quo[0]) | (rem != '0);
    full_c   = {1'b1, mant_c, guard_c, 24'd0} >> sh_c;
    rnd_c    = 1'(full_c >> 24) & (sticky_c | (full_c[23:0] != 24'd0) | frac_c[0]);
    body_c   = body_c + 31'(rnd_c);
`endif
    if (exp_c >= 12'sd255) pack_c = {sign_q, 8'hFF, 23'd0};
    else                   pack_c = {sign_q, body_c};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c) state_nx = spec_c ? DONE : DIV;
      DIV:     if (cnt == CW'(ITERS - 1)) state_nx = PACK;
      PACK:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM output decode; registered one cycle later.
  always_comb begin
    busy_nx = (state != IDLE);
    done_nx = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (done_nx) result <= res_q;
    end
  end

  // Datapath: capture, iterate, pack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= 32'h0;
    end else if (accept_c) begin
      cnt     <= '0;
      divisor <= ub_c[MW-1:0];
      rem     <= {1'b0, ua_c[MW-1:0]};
      quo     <= '0;
      exp_q   <= $signed(ua_c[EW+MW-1:MW]) - $signed(ub_c[EW+MW-1:MW]) + 12'sd127;
      sign_q  <= sign_c;
      if (spec_c) res_q <= spec_res_c;
    end else if (state == DIV) begin
      rem <= rem_nx_c;
      quo <= {quo[ITERS-2:0], ge_c};
      cnt <= (cnt == CW'(ITERS - 1)) ? '0 : cnt + CW'(1);
    end else if (state == PACK) begin
      res_q <= pack_c;
    end
  end
endmodule

// File: tb/tb_fp32_div.sv
// Randomised and directed bench for fp32_div, checked against an exact integer quotient model.
module tb_fp32_div;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  int          checks = 0;
  int          fails  = 0;

  fp32_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF) || (x[30:0] == 31'd0) || (y[30:0] == 31'd0);
  endfunction

  // Exact quotient of the real values, then truncated or rounded to single precision.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic        s, xn, yn, xi, yi, xz, yz;
    logic [63:0] mx, my, q, r, sig, outv;
    int          ex, ey, p, bexp, sh;
`ifdef FP32_DIV_ROUND_EN
    logic        g, st;
    logic [63:0] lowmask;
`endif
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    xz = (x[30:0] == 31'd0);
    yz = (y[30:0] == 31'd0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00001;
    if (xi || yz) return {s, 8'hFF, 23'd0};
    if (xz || yi) return {s, 31'd0};
    mx = {40'd0, (x[30:23] != 8'd0), x[22:0]};
    my = {40'd0, (y[30:23] != 8'd0), y[22:0]};
    ex = (x[30:23] != 8'd0) ? int'(x[30:23]) : 1;
    ey = (y[30:23] != 8'd0) ? int'(y[30:23]) : 1;
    while (!mx[23]) begin mx = mx << 1; ex--; end
    while (!my[23]) begin my = my << 1; ey--; end
    q    = (mx << 40) / my;
    r    = (mx << 40) % my;
    p    = q[40] ? 40 : 39;
    bexp = ex - ey + 127 + p - 40;
    if (bexp >= 255) return {s, 8'hFF, 23'd0};
    sh = p - 23;
    if (bexp < 1) sh += 1 - bexp;
    if (sh > 60) sh = 60;
    sig  = q >> sh;
    outv = sig;
    if (bexp >= 1) outv = outv + (64'(bexp - 1) << 23);
`ifdef FP32_DIV_ROUND_EN
    g       = q[sh-1];
    lowmask = (64'd1 << (sh - 1)) - 64'd1;
    st      = (r != 64'd0) || ((q & lowmask) != 64'd0);
    if (g && (st || sig[0])) outv = outv + 64'd1;
`else
    if (r == 64'hFFFF_FFFF_FFFF_FFFF) outv = outv + 64'd0;
`endif
    if (outv >= 64'h7F80_0000) return {s, 8'hFF, 23'd0};
    return {s, outv[30:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          c;
    logic [7:0]  e;
    logic [22:0] f;
    c = int'($urandom_range(0, 19));
    f = 23'($urandom);
    case (c)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      2:       e = 8'($urandom_range(240, 254));
      3:       e = 8'($urandom_range(1, 12));
      4:       begin e = 8'h00; f = 23'd0; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Issue one division; optionally pulse start again at sample index inj while busy.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv,
                       input int inj, input string tag);
    int k, busy_cnt, lat;
    bit got, busy_at;
    lat = is_special(x, y) ? 1 : 28;
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; got = 1'b0; busy_cnt = 0; busy_at = 1'b0;
    while (!got && k < 40) begin
      start = (k == inj);
      if (k == inj) begin a = $urandom; b = $urandom; end
      if (done) begin
        got = 1'b1; busy_at = busy;
      end else begin
        if (busy) busy_cnt++;
        @(negedge clk); k++;
      end
    end
    check(32'(got), 32'd1, {tag, "_done_seen"});
    check(32'(k), 32'(lat), {tag, "_latency"});
    check(32'(busy_cnt), 32'(lat - 1), {tag, "_busy_before_done"});
    check(32'(busy_at), 32'd1, {tag, "_busy_at_done"});
    check(result, expv, {tag, "_result"});
    @(negedge clk); start = 1'b0;
    check(32'(done), 32'd0, {tag, "_done_pulse"});
    repeat (2) @(negedge clk);
    check(32'(busy), 32'd0, {tag, "_no_queued_op"});
    check(result, expv, {tag, "_result_hold"});
  endtask

  initial begin
    int  k;
    bit  seen;
    logic [31:0] x, y;
    rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    check(32'(busy), 32'd0, "reset_busy");
    check(32'(done), 32'd0, "reset_done");
    check(result, 32'h0, "reset_result");
    rst_n = 1'b1;

    do_op(32'h40C00000, 32'h40000000, 32'h40400000, -1, "six_by_two");
`ifdef FP32_DIV_ROUND_EN
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, -1, "one_third");
`else
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, -1, "one_third");
`endif
    do_op(32'h3F800000, 32'h00000000, 32'h7F800000, -1, "x_div_zero");
    do_op(32'h00000000, 32'h00000000, 32'h7FC00001, -1, "zero_div_zero");
    do_op(32'h7F800000, 32'h7F800000, 32'h7FC00001, -1, "inf_div_inf");
    do_op(32'hBF800000, 32'h7F800000, 32'h80000000, -1, "x_div_inf");
    do_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, -1, "overflow");
    do_op(32'h00800000, 32'h40000000, 32'h00400000, -1, "to_denormal");
    do_op(32'h00000001, 32'h3F800000, 32'h00000001, -1, "min_denormal");
    do_op(32'h7FC12345, 32'h3F800000, 32'h7FC00001, -1, "nan_operand");

    for (int i = 0; i < 40; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      do_op(x, y, ref_div(x, y), -1, $sformatf("rand%0d_%h_%h", i, x, y));
    end

    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 5, "start_mid_div");
    do_op(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 28, "start_in_done");

    // Abort during DIV with an asynchronous reset.
    @(negedge clk); a = 32'h41200000; b = 32'h40A00000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(32'(busy), 32'd0, "abort_busy");
    check(32'(done), 32'd0, "abort_done");
    check(result, 32'h0, "abort_result");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (k = 0; k < 32; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check(32'(seen), 32'd0, "abort_no_done");
    do_op(32'h41200000, 32'h40A00000, 32'h40000000, -1, "after_abort");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
